// File: rtl/dtw_traceback_pkg.sv
// Shared definitions for the DTW traceback slice.
// Holds grid/lane sizing, the path-direction codes written by the distance
// core, the traceback FSM encoding, and helpers that locate each lane's
// slice in the packed capture buses. Lane 0 sits in the most significant
// slice of every packed bus.
package dtw_traceback_pkg;

  localparam int LANES = 6;        // systolic lanes captured per cycle
  localparam int IW    = 5;        // index width per lane
  localparam int DW    = 16;       // accumulated distance width
  localparam int LW    = 6;        // path length counter width
  localparam int GRID  = 1 << IW;  // map is GRID x GRID cells

  typedef enum logic [1:0] {
    PATH_DIAG = 2'b00,  // predecessor (t-1, r-1)
    PATH_UP   = 2'b01,  // predecessor (t-1, r)
    PATH_LEFT = 2'b10,  // predecessor (t, r-1)
    PATH_NONE = 2'b11   // no predecessor / never written
  } path_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // LSB of lane l inside the packed index buses.
  function automatic int idx_lsb(input int l);
    return (LANES - 1 - l) * IW;
  endfunction

  // LSB of lane l inside the packed path-code bus.
  function automatic int path_lsb(input int l);
    return (LANES - 1 - l) * 2;
  endfunction

  // LSB of lane l inside the packed distance bus.
  function automatic int dist_lsb(input int l);
    return (LANES - 1 - l) * DW;
  endfunction

  // Bit of the per-lane valid vector that enables lane l.
  function automatic int vld_bit(input int l);
    return LANES - 1 - l;
  endfunction

endpackage

// File: rtl/dtw_traceback_if.sv
// Bus bundle for dtw_traceback: the 6-lane capture stream coming from the
// distance core and the warping-path step stream going to the readout side.
//
// Step handshake: a step transfers on every rising clk edge where
// o_step_vld and i_step_rdy are both high. Once o_step_vld is raised it
// stays high, with o_step_t/o_step_r unchanged, until that transfer happens.
// i_step_rdy may change freely and is never required before valid.
//
// Modports: slave = traceback block, master = producer/consumer side.
interface dtw_traceback_if
  import dtw_traceback_pkg::*;
();

  logic [LANES-1:0]    i_pvalid;
  logic [LANES*IW-1:0] i_tindex;
  logic [LANES*IW-1:0] i_rindex;
  logic [LANES*2-1:0]  i_path;
  logic [LANES*DW-1:0] i_D;

  logic                o_step_vld;
  logic                i_step_rdy;
  logic [IW-1:0]       o_step_t;
  logic [IW-1:0]       o_step_r;

  modport slave (
    input  i_pvalid, i_tindex, i_rindex, i_path, i_D, i_step_rdy,
    output o_step_vld, o_step_t, o_step_r
  );

  modport master (
    output i_pvalid, i_tindex, i_rindex, i_path, i_D, i_step_rdy,
    input  o_step_vld, o_step_t, o_step_r
  );

endinterface

// File: rtl/dtw_path_map.sv
// 32x32 array of 2-bit path-direction codes.
// Ports:
//   clk, nrst   clock, asynchronous active-low reset (all cells -> 2'b11)
//   i_clr       synchronous clear (all cells -> 2'b11)
//   i_we        per-lane write enable, packed like the capture valid bus
//   i_t, i_r    per-lane cell coordinates (packed lane slices)
//   i_code      per-lane direction code (packed lane slices)
//   i_rd_t/r    combinational read address
//   o_rd_code   code stored at the read address
// Lanes are applied in ascending order inside one process, so when two
// lanes hit the same cell in a cycle the higher lane number wins.
module dtw_path_map
  import dtw_traceback_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_clr,
  input  logic [LANES-1:0]    i_we,
  input  logic [LANES*IW-1:0] i_t,
  input  logic [LANES*IW-1:0] i_r,
  input  logic [LANES*2-1:0]  i_code,
  input  logic [IW-1:0]       i_rd_t,
  input  logic [IW-1:0]       i_rd_r,
  output path_t               o_rd_code
);

  logic [1:0] map_q [GRID][GRID];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int a = 0; a < GRID; a++)
        for (int b = 0; b < GRID; b++)
          map_q[a][b] <= 2'b11;
    end else if (i_clr) begin
      for (int a = 0; a < GRID; a++)
        for (int b = 0; b < GRID; b++)
          map_q[a][b] <= 2'b11;
    end else begin
      for (int l = 0; l < LANES; l++)
        if (i_we[vld_bit(l)])
          map_q[i_t[idx_lsb(l) +: IW]][i_r[idx_lsb(l) +: IW]] <= i_code[path_lsb(l) +: 2];
    end
  end

  assign o_rd_code = path_t'(map_q[i_rd_t][i_rd_r]);

endmodule

// File: rtl/dtw_traceback.sv
// DTW traceback: captures the distance core's path stream into a direction
// map while idle, then walks from (i_lent,i_lenr) back to (0,0), emitting
// one path cell per accepted step and reporting path length, error and the
// accumulated distance of the end cell.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   i_clr            synchronous clear of FSM, map and outputs
//   bus              capture stream + step handshake (slave modport)
//   i_start          begin traceback (honoured in IDLE only)
//   i_lent, i_lenr   end cell coordinates (lengths minus one)
//   o_busy           high while walking
//   o_done           one-cycle pulse after the final step is accepted
//   o_err            illegal walk detected; held until next i_start
//   o_len            cells emitted in the last walk
//   o_dist           distance of the end cell, loaded with o_done
//   o_state          FSM state, for debug visibility
module dtw_traceback
  import dtw_traceback_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_clr,
  dtw_traceback_if.slave    bus,
  input  logic              i_start,
  input  logic [IW-1:0]     i_lent,
  input  logic [IW-1:0]     i_lenr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [LW-1:0]     o_len,
  output logic [DW-1:0]     o_dist,
  output state_t            o_state
);

  state_t        state_q, state_d;
  logic [IW-1:0] cur_t, cur_r;
  logic [IW-1:0] next_t, next_r;
  logic [DW-1:0] end_dist;
  path_t         rd_code;
  logic          accept, at_origin, walk_err;

  // Capture is only allowed while idle; writes during a walk are dropped.
  dtw_path_map u_map (
    .clk       (clk),
    .nrst      (nrst),
    .i_clr     (i_clr),
    .i_we      (bus.i_pvalid & {LANES{state_q == ST_IDLE}}),
    .i_t       (bus.i_tindex),
    .i_r       (bus.i_rindex),
    .i_code    (bus.i_path),
    .i_rd_t    (cur_t),
    .i_rd_r    (cur_r),
    .o_rd_code (rd_code)
  );

  // The step output is valid for the whole TRACE state; the last accepted
  // step moves the FSM to DONE, which drops valid.
  assign accept    = (state_q == ST_TRACE) && bus.i_step_rdy;
  assign at_origin = (cur_t == '0) && (cur_r == '0);

  // Predecessor of the current cell and whether moving there is legal.
  // Reaching (0,0) ends the walk regardless of the code stored there.
  always_comb begin
    next_t   = cur_t;
    next_r   = cur_r;
    walk_err = 1'b0;
    case (rd_code)
      PATH_DIAG: begin
        walk_err = (cur_t == '0) || (cur_r == '0);
        next_t   = cur_t - 1'b1;
        next_r   = cur_r - 1'b1;
      end
      PATH_UP: begin
        walk_err = (cur_t == '0);
        next_t   = cur_t - 1'b1;
      end
      PATH_LEFT: begin
        walk_err = (cur_r == '0);
        next_r   = cur_r - 1'b1;
      end
      default: walk_err = 1'b1;
    endcase
    if (at_origin) walk_err = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)      state_q <= ST_IDLE;
    else if (i_clr) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    o_busy         = 1'b0;
    bus.o_step_vld = 1'b0;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_TRACE;
      ST_TRACE: begin
        o_busy         = 1'b1;
        bus.o_step_vld = 1'b1;
        if (accept && (at_origin || walk_err)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_t    <= '0;
      cur_r    <= '0;
      o_len    <= '0;
      o_err    <= 1'b0;
      o_done   <= 1'b0;
      o_dist   <= '0;
      end_dist <= '1;
    end else if (i_clr) begin
      cur_t    <= '0;
      cur_r    <= '0;
      o_len    <= '0;
      o_err    <= 1'b0;
      o_done   <= 1'b0;
      o_dist   <= '0;
      end_dist <= '1;
    end else begin
      o_done <= 1'b0;
      if (state_q == ST_IDLE) begin
        // End-cell distance follows the same lane priority as the map.
        for (int l = 0; l < LANES; l++)
          if (bus.i_pvalid[vld_bit(l)] &&
              bus.i_tindex[idx_lsb(l) +: IW] == i_lent &&
              bus.i_rindex[idx_lsb(l) +: IW] == i_lenr)
            end_dist <= bus.i_D[dist_lsb(l) +: DW];
        if (i_start) begin
          cur_t <= i_lent;
          cur_r <= i_lenr;
          o_len <= '0;
          o_err <= 1'b0;
        end
      end
      if (accept) begin
        o_len <= o_len + LW'(1);
        if (at_origin || walk_err) begin
          o_done <= 1'b1;
          o_err  <= walk_err;
          o_dist <= end_dist;
        end else begin
          cur_t <= next_t;
          cur_r <= next_r;
        end
      end
    end
  end

  assign bus.o_step_t = cur_t;
  assign bus.o_step_r = cur_r;
  assign o_state      = state_q;

endmodule

// File: tb/tb_dtw_traceback.sv
// Self-checking bench for dtw_traceback. A behavioural model keeps the
// direction map as a plain array, applies lane writes in priority order and
// derives the expected walk by following the direction rules directly.
module tb_dtw_traceback;
  import dtw_traceback_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic i_clr = 1'b0;
  logic i_start = 1'b0;
  logic [IW-1:0] i_lent = '0;
  logic [IW-1:0] i_lenr = '0;
  logic o_busy, o_done, o_err;
  logic [LW-1:0] o_len;
  logic [DW-1:0] o_dist;
  state_t o_state;

  always #5 clk = ~clk;

  dtw_traceback_if bus ();

  dtw_traceback dut (
    .clk     (clk),
    .nrst    (nrst),
    .i_clr   (i_clr),
    .bus     (bus.slave),
    .i_start (i_start),
    .i_lent  (i_lent),
    .i_lenr  (i_lenr),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err),
    .o_len   (o_len),
    .o_dist  (o_dist),
    .o_state (o_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  int mdl_map [GRID][GRID];
  int mdl_dist;
  logic [2*IW-1:0] exp_q [$];
  int exp_len;
  int exp_err;

  bit ln_pv [LANES];
  int ln_t [LANES];
  int ln_r [LANES];
  int ln_c [LANES];
  int ln_d [LANES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < GRID; a++)
      for (int b = 0; b < GRID; b++)
        mdl_map[a][b] = 3;
    mdl_dist = 32'hffff;
  endtask

  // Expected walk: follow stored directions from the end cell until (0,0),
  // an unwritten cell, or a move that would leave the grid.
  task automatic model_walk();
    int t;
    int r;
    bit stop;
    t = int'(i_lent);
    r = int'(i_lenr);
    stop = 0;
    exp_q.delete();
    exp_len = 0;
    exp_err = 0;
    for (int k = 0; k < 64 && !stop; k++) begin
      exp_q.push_back({t[IW-1:0], r[IW-1:0]});
      exp_len++;
      if (t == 0 && r == 0) stop = 1;
      else begin
        case (mdl_map[t][r])
          0: if (t == 0 || r == 0) begin exp_err = 1; stop = 1; end
             else begin t = t - 1; r = r - 1; end
          1: if (t == 0) begin exp_err = 1; stop = 1; end
             else t = t - 1;
          2: if (r == 0) begin exp_err = 1; stop = 1; end
             else r = r - 1;
          default: begin exp_err = 1; stop = 1; end
        endcase
      end
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic set_lane(input int l, input int t, input int r, input int c, input int d);
    ln_pv[l] = 1;
    ln_t[l] = t;
    ln_r[l] = r;
    ln_c[l] = c;
    ln_d[l] = d;
  endtask

  task automatic drive_lanes();
    for (int l = 0; l < LANES; l++) begin
      bus.i_pvalid[LANES-1-l] = ln_pv[l];
      bus.i_tindex[(LANES-1-l)*IW +: IW] = ln_t[l][IW-1:0];
      bus.i_rindex[(LANES-1-l)*IW +: IW] = ln_r[l][IW-1:0];
      bus.i_path[(LANES-1-l)*2 +: 2] = ln_c[l][1:0];
      bus.i_D[(LANES-1-l)*DW +: DW] = ln_d[l][DW-1:0];
    end
    for (int l = 0; l < LANES; l++)
      if (ln_pv[l]) begin
        mdl_map[ln_t[l]][ln_r[l]] = ln_c[l];
        if (ln_t[l] == int'(i_lent) && ln_r[l] == int'(i_lenr)) mdl_dist = ln_d[l];
      end
    @(negedge clk);
    bus.i_pvalid = '0;
    for (int l = 0; l < LANES; l++) ln_pv[l] = 0;
  endtask

  task automatic do_clr();
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    model_clear();
  endtask

  // Fill cells t<nt, r<nr, keeping edge cells legal; none_pct injects 11s.
  task automatic fill_grid(input int nt, input int nr, input bit allow_diag, input int none_pct);
    int l;
    int c;
    l = 0;
    for (int t = 0; t < nt; t++)
      for (int r = 0; r < nr; r++) begin
        if (t == 0) c = 2;
        else if (r == 0) c = 1;
        else c = allow_diag ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
        if (none_pct > 0 && int'($urandom_range(0, 99)) < none_pct) c = 3;
        set_lane(l, t, r, c, int'($urandom_range(0, 65535)));
        l++;
        if (l == LANES) begin drive_lanes(); l = 0; end
      end
    if (l != 0) drive_lanes();
  endtask

  // rdy_mode: 0 = always ready, 1 = toggling starting stalled, 2 = random.
  task automatic run_trace(input string tag, input int rdy_mode);
    bit got_done;
    bit prev_acc;
    logic rdy;
    model_walk();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_first_vld"}, bus.o_step_vld, 1);
    got_done = 0;
    prev_acc = 0;
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      if (rdy_mode == 0) rdy = 1'b1;
      else if (rdy_mode == 1) rdy = cyc[0];
      else rdy = 1'($urandom_range(0, 1));
      bus.i_step_rdy = rdy;
      if (o_done) begin
        got_done = 1;
        check({tag, "_done_lat"}, prev_acc, 1);
        check({tag, "_steps_left"}, exp_q.size(), 0);
        check({tag, "_len"}, o_len, exp_len);
        check({tag, "_err"}, o_err, exp_err);
        check({tag, "_dist"}, o_dist, mdl_dist);
      end else if (bus.o_step_vld) begin
        if (exp_q.size() == 0) check({tag, "_extra_step"}, {bus.o_step_t, bus.o_step_r}, 32'hdead);
        else begin
          check({tag, "_step"}, {bus.o_step_t, bus.o_step_r}, exp_q[0]);
          if (rdy) void'(exp_q.pop_front());
        end
      end
      prev_acc = bus.o_step_vld && rdy;
      @(negedge clk);
    end
    bus.i_step_rdy = 1'b0;
    if (!got_done) check({tag, "_done_timeout"}, 0, 1);
    check({tag, "_done_pulse"}, o_done, 0);
    check({tag, "_idle"}, o_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.i_pvalid = '0;
    bus.i_tindex = '0;
    bus.i_rindex = '0;
    bus.i_path = '0;
    bus.i_D = '0;
    bus.i_step_rdy = 1'b0;
    for (int l = 0; l < LANES; l++) ln_pv[l] = 0;
    model_clear();

    // reset state
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_vld", bus.o_step_vld, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_len", o_len, 0);
    check("rst_dist", o_dist, 0);
    check("rst_idx", {bus.o_step_t, bus.o_step_r}, 0);
    check("rst_state", o_state, ST_IDLE);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // pure diagonal 4x4
    i_lent = 5'd3; i_lenr = 5'd3;
    for (int k = 0; k < 4; k++) set_lane(k, k, k, 0, int'($urandom_range(0, 65535)));
    drive_lanes();
    run_trace("diag", 0);
    check("diag_len_4", o_len, 4);
    check("diag_err_0", o_err, 0);

    // 5x3 mixed up/left, then the same map with toggling ready
    do_clr();
    i_lent = 5'd4; i_lenr = 5'd2;
    fill_grid(5, 3, 0, 0);
    run_trace("grid53", 0);
    run_trace("grid53_toggle", 1);

    // unwritten cell (2,1) on the walk
    do_clr();
    i_lent = 5'd3; i_lenr = 5'd2;
    set_lane(0, 3, 2, 1, 16'h1234);
    set_lane(1, 2, 2, 2, 16'h0001);
    drive_lanes();
    run_trace("none21", 0);
    check("none21_err", o_err, 1);
    check("none21_len", o_len, 3);

    // lane priority on map cell and end-cell distance
    do_clr();
    i_lent = 5'd2; i_lenr = 5'd2;
    set_lane(0, 1, 1, 0, 16'h0000);
    set_lane(5, 1, 1, 1, 16'h0005);
    set_lane(1, 2, 2, 0, 16'h1111);
    set_lane(4, 2, 2, 0, 16'h4444);
    set_lane(2, 0, 1, 2, 16'h2222);
    drive_lanes();
    run_trace("prio", 0);
    check("prio_len", o_len, 4);
    check("prio_dist", o_dist, 16'h4444);

    // degenerate single-cell walk
    do_clr();
    i_lent = 5'd0; i_lenr = 5'd0;
    set_lane(3, 0, 0, 3, 16'habcd);
    drive_lanes();
    run_trace("single", 0);
    check("single_len", o_len, 1);
    check("single_err", o_err, 0);

    // randomized grids with random ready, occasional holes
    for (int it = 0; it < 3; it++) begin
      do_clr();
      i_lent = 5'($urandom_range(0, 31));
      i_lenr = 5'($urandom_range(0, 31));
      fill_grid(int'(i_lent) + 1, int'(i_lenr) + 1, 1, (it == 2) ? 3 : 0);
      run_trace("rand", 2);
    end

    // async reset mid-walk, then restart on the cleared map
    i_lent = 5'd5; i_lenr = 5'd4;
    fill_grid(6, 5, 1, 0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    bus.i_step_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", o_busy, 1);
    nrst = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_vld", bus.o_step_vld, 0);
    @(negedge clk);
    nrst = 1'b1;
    model_clear();
    @(negedge clk);
    check("post_rst_done", o_done, 0);
    run_trace("after_rst", 0);
    check("after_rst_err", o_err, 1);
    check("after_rst_len", o_len, 1);
    check("after_rst_dist", o_dist, 16'hffff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
